// File: rtl/pdn_pkg.sv
// Shared types and sizing helpers for the power-distribution sequencer.
package pdn_pkg;

    typedef enum logic [2:0] {
        OFF,
        UP_EN,
        UP_SETTLE,
        ON,
        DN_SETTLE,
        FAULT
    } pdn_state_e;

    // Step counter must hold the larger of the two compare limits.
    function automatic int cnt_width(input int timeout_cyc, input int settle_cyc);
        int m;
        m = (timeout_cyc > settle_cyc) ? timeout_cyc : settle_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pdn_sync2.sv
// Multi-bit two-flop synchroniser for the asynchronous power-good inputs.
module pdn_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pdn_power_sequencer.sv
// Ordered power-up/power-down sequencer for NUM_DOMAINS supplies with
// power-good timeout and loss supervision.
module pdn_power_sequencer
    import pdn_pkg::*;
#(
    parameter int NUM_DOMAINS = 6,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SETTLE_CYC  = 16,
    parameter int IDX_W       = $clog2(NUM_DOMAINS),
    parameter int CNT_W       = cnt_width(TIMEOUT_CYC, SETTLE_CYC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pwr_req,
    input  logic [NUM_DOMAINS-1:0] pg,
    input  logic                   fault_clr,
    output logic [NUM_DOMAINS-1:0] en,
    output logic                   busy,
    output logic                   all_on,
    output logic                   fault,
    output logic [IDX_W-1:0]       fault_idx
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    pdn_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       fault_idx_q, fault_idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] en_q;
    logic                   busy_q, all_on_q, fault_q;

    logic [NUM_DOMAINS-1:0] pg_s;
    logic [NUM_DOMAINS-1:0] good_mask;
    logic [NUM_DOMAINS-1:0] lost;
    logic                   lost_any;
    logic [IDX_W-1:0]       lost_idx;

    pdn_sync2 #(
        .WIDTH(NUM_DOMAINS)
    ) u_pg_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pg),
        .q_o (pg_s)
    );

    function automatic logic [NUM_DOMAINS-1:0] en_decode(input pdn_state_e st,
                                                         input logic [IDX_W-1:0] ix);
        logic [NUM_DOMAINS-1:0] e;
        e = '0;
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            case (st)
                UP_EN, UP_SETTLE: e[j] = (j <= int'(ix));
                DN_SETTLE:        e[j] = (j < int'(ix));
                ON:               e[j] = 1'b1;
                default:          e[j] = 1'b0;
            endcase
        end
        return e;
    endfunction

    // Domains already reported good must stay good; the one being ramped is excluded in UP_EN.
    always_comb begin
        good_mask = '0;
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            case (state_q)
                UP_EN:     good_mask[j] = (j < int'(idx_q));
                UP_SETTLE: good_mask[j] = (j <= int'(idx_q));
                ON:        good_mask[j] = 1'b1;
                default:   good_mask[j] = 1'b0;
            endcase
        end
    end

    assign lost     = good_mask & ~pg_s;
    assign lost_any = |lost;

    always_comb begin
        lost_idx = '0;
        for (int j = NUM_DOMAINS - 1; j >= 0; j--) begin
            if (lost[j]) lost_idx = IDX_W'(j);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fault_idx_d = fault_idx_q;
        case (state_q)
            OFF: begin
                if (pwr_req) begin
                    state_d = UP_EN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            UP_EN: begin
                if (lost_any) begin
                    state_d     = FAULT;
                    fault_idx_d = lost_idx;
                    cnt_d       = '0;
                end else if (!pwr_req) begin
                    state_d = DN_SETTLE;
                    cnt_d   = '0;
                end else if (pg_s[idx_q]) begin
                    state_d = UP_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = FAULT;
                    fault_idx_d = idx_q;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UP_SETTLE: begin
                if (lost_any) begin
                    state_d     = FAULT;
                    fault_idx_d = lost_idx;
                    cnt_d       = '0;
                end else if (!pwr_req) begin
                    state_d = DN_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ON;
                    end else begin
                        state_d = UP_EN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ON: begin
                if (lost_any) begin
                    state_d     = FAULT;
                    fault_idx_d = lost_idx;
                end else if (!pwr_req) begin
                    state_d = DN_SETTLE;
                    idx_d   = IDX_LAST;
                    cnt_d   = '0;
                end
            end
            DN_SETTLE: begin
                // pwr_req is deliberately ignored until the ramp-down reaches OFF.
                if (cnt_q == ST_LAST) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = OFF;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FAULT: begin
                if (fault_clr && !pwr_req) begin
                    state_d     = OFF;
                    idx_d       = '0;
                    cnt_d       = '0;
                    fault_idx_d = '0;
                end
            end
            default: begin
                state_d = OFF;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            fault_idx_q <= '0;
            en_q        <= '0;
            busy_q      <= 1'b0;
            all_on_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fault_idx_q <= fault_idx_d;
            en_q        <= en_decode(state_d, idx_d);
            busy_q      <= (state_d inside {UP_EN, UP_SETTLE, DN_SETTLE});
            all_on_q    <= (state_d == ON);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign en        = en_q;
    assign busy      = busy_q;
    assign all_on    = all_on_q;
    assign fault     = fault_q;
    assign fault_idx = fault_idx_q;

endmodule
